// File: rtl/dmem_pkg.sv
// Shared types and defaults for the stall-aware data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_LATENCY = 3;
    localparam int unsigned DATA_W      = 16;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, asynchronous read, contents survive reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one request, stalls for LATENCY edges, pulses done.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    op_e                 op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [15:0]         data_out_q, data_out_d;
    logic                stall_q, stall_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accepting, legal, accept, illegal;
    logic                to_resp;
    op_e                 resp_op;
    logic [ADDR_W-1:0]   resp_addr;
    logic [15:0]         resp_data;
    logic                mem_we;
    logic [15:0]         mem_rdata;
    logic                unused_addr;

    assign unused_addr = ^addr[15:ADDR_W+1];

    assign accepting = (state_q == IDLE) || (state_q == RESP);
    assign legal     = (req_rd ^ req_wr) & ~addr[0];
    assign accept    = accepting & legal;
    assign illegal   = accepting & (req_rd | req_wr) & ~legal;

    // With LATENCY=1 the accept edge is also the RESP-entry edge, so storage is
    // addressed straight from the request inputs rather than the capture registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
        to_resp   = 1'b0;
        resp_op   = op_q;
        resp_addr = addr_q;
        resp_data = wdata_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    op_d    = req_wr ? OP_WR : OP_RD;
                    addr_d  = addr[ADDR_W:1];
                    wdata_d = data_in;
                    if (LATENCY == 1) begin
                        state_d   = RESP;
                        to_resp   = 1'b1;
                        resp_op   = op_d;
                        resp_addr = addr_d;
                        resp_data = data_in;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end else if (illegal) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    to_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we = to_resp && (resp_op == OP_WR);

    always_comb begin
        data_out_d = data_out_q;
        if (to_resp && (resp_op == OP_RD)) begin
            data_out_d = mem_rdata;
        end
        stall_d = (state_d == BUSY);
        done_d  = (state_d == RESP);
    end

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (resp_addr),
        .wdata (resp_data),
        .raddr (resp_addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_RD;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            stall_q    <= stall_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign data_out = data_out_q;
    assign stall    = stall_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
